// File: rtl/gpio_input_capture.sv
// GPIO read-side capture: pin synchronizer, port-read snapshot and sticky edge interrupt flags.
// Optional per-pin debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_input_capture #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_io_in,
    input  logic [WIDTH-1:0] i_port_dir,
    input  logic             i_port_rd,
    output logic [WIDTH-1:0] o_port_read_data,
    output logic             o_read_valid,
    input  logic [WIDTH-1:0] i_edge_en,
    input  logic [WIDTH-1:0] i_edge_pol,
    input  logic [WIDTH-1:0] i_irq_clr,
    output logic [WIDTH-1:0] o_irq_flags,
    output logic             o_irq
);

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned WARM_LEN = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
`else
    localparam int unsigned WARM_LEN = SYNC_STAGES + 1;
`endif
    // Sized for the longer (debounced) warm-up so both builds share one counter width.
    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + DEBOUNCE_CYCLES + 2);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WARM_W-1:0]   r_warm;
    logic [WARM_W-1:0]   w_warm_nxt;
    logic [WIDTH-1:0]    r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]    w_sync_q;
    logic [WIDTH-1:0]    w_level;
    logic [WIDTH-1:0]    r_prev;
    logic [WIDTH-1:0]    r_read_data;
    logic                r_read_valid;
    logic [WIDTH-1:0]    r_flags;
    logic [WIDTH-1:0]    w_rise;
    logic [WIDTH-1:0]    w_fall;
    logic [WIDTH-1:0]    w_det;
    logic                w_run;

    // Multi-flop synchronizer per pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= i_io_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [WIDTH-1:0] r_filt;
    logic [DB_W-1:0]  r_db_cnt [WIDTH];

    // Filtered level follows sync_q only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (w_sync_q[i] != r_filt[i]) begin
                    if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_filt[i]   <= w_sync_q[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_sync_q;
`endif

    // State register and warm-up counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WARMUP;
            r_warm  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_warm  <= w_warm_nxt;
        end
    end

    // Leave WARMUP on the edge where the counter reaches WARM_LEN.
    always_comb begin
        w_state_nxt = r_state;
        w_warm_nxt  = r_warm;
        case (r_state)
            ST_WARMUP: begin
                w_warm_nxt = r_warm + WARM_W'(1);
                if (r_warm == WARM_W'(WARM_LEN - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_run  = (r_state == ST_RUN);
    assign w_rise = w_level & ~r_prev;
    assign w_fall = ~w_level & r_prev;
    assign w_det  = {WIDTH{w_run}} & i_edge_en & ~i_port_dir &
                    ((i_edge_pol & w_rise) | (~i_edge_pol & w_fall));

    // Previous sample, read snapshot and sticky flags (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_flags      <= '0;
        end else begin
            r_prev       <= w_level;
            r_read_valid <= i_port_rd;
            if (i_port_rd) begin
                r_read_data <= w_level & ~i_port_dir;
            end
            r_flags <= w_det | (r_flags & ~i_irq_clr);
        end
    end

    assign o_port_read_data = r_read_data;
    assign o_read_valid     = r_read_valid;
    assign o_irq_flags      = r_flags;
    assign o_irq            = |r_flags;

endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed self-checking bench for gpio_input_capture (default SYNC_STAGES=2, WIDTH=8).
module tb_gpio_input_capture;

    localparam int SS = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int LAT_EDGE = SS + 1 + DB;

    logic       clk;
    logic       rst_n;
    logic [7:0] io_in;
    logic [7:0] port_dir;
    logic       port_rd;
    logic [7:0] port_read_data;
    logic       read_valid;
    logic [7:0] edge_en;
    logic [7:0] edge_pol;
    logic [7:0] irq_clr;
    logic [7:0] irq_flags;
    logic       irq;

    int n_checks = 0;
    int n_err    = 0;

    gpio_input_capture #(.WIDTH(8), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_io_in          (io_in),
        .i_port_dir       (port_dir),
        .i_port_rd        (port_rd),
        .o_port_read_data (port_read_data),
        .o_read_valid     (read_valid),
        .i_edge_en        (edge_en),
        .i_edge_pol       (edge_pol),
        .i_irq_clr        (irq_clr),
        .o_irq_flags      (irq_flags),
        .o_irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        io_in    = 8'hFF;
        port_dir = 8'h00;
        port_rd  = 1'b0;
        edge_en  = 8'hFF;
        edge_pol = 8'hFF;
        irq_clr  = 8'h00;
        wait_cyc(3);
        check("rst_data", 32'(port_read_data), 32'h00);
        check("rst_valid", 32'(read_valid), 32'h0);
        check("rst_flags", 32'(irq_flags), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);

        // Pins high out of reset must not flag a rising edge.
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            wait_cyc(1);
            check("warmup_flags", 32'(irq_flags), 32'h00);
            check("warmup_irq", 32'(irq), 32'h0);
        end

        // Single read with output-pin masking.
        edge_en  = 8'h00;
        io_in    = 8'hA5;
        port_dir = 8'h0F;
        wait_cyc(3 + DB);
        port_rd = 1'b1;
        wait_cyc(1);
        port_rd = 1'b0;
        check("rd_data", 32'(port_read_data), 32'hA0);
        check("rd_valid", 32'(read_valid), 32'h1);
        wait_cyc(1);
        check("rd_valid_drop", 32'(read_valid), 32'h0);
        check("rd_data_hold", 32'(port_read_data), 32'hA0);

        // Held strobe gives fresh snapshots each cycle.
        port_dir = 8'h00;
        port_rd  = 1'b1;
        wait_cyc(1);
        check("rd2_data0", 32'(port_read_data), 32'hA5);
        check("rd2_valid0", 32'(read_valid), 32'h1);
        port_dir = 8'hFF;
        wait_cyc(1);
        check("rd2_data1", 32'(port_read_data), 32'h00);
        check("rd2_valid1", 32'(read_valid), 32'h1);
        port_rd  = 1'b0;
        port_dir = 8'h00;
        wait_cyc(1);
        check("rd2_valid_end", 32'(read_valid), 32'h0);

        // Rising edge on pin 0, latency and clear.
        io_in = 8'hA4;
        wait_cyc(3 + DB + 2);
        edge_en  = 8'h01;
        edge_pol = 8'h01;
        wait_cyc(1);
        check("rise_pre", 32'(irq_flags), 32'h00);
        io_in = 8'hA5;
        wait_cyc(LAT_EDGE - 1);
        check("rise_early", 32'(irq_flags), 32'h00);
        wait_cyc(1);
        check("rise_flag", 32'(irq_flags), 32'h01);
        check("rise_irq", 32'(irq), 32'h1);
        irq_clr = 8'h01;
        wait_cyc(1);
        irq_clr = 8'h00;
        check("clr_flag", 32'(irq_flags), 32'h00);
        check("clr_irq", 32'(irq), 32'h0);
        io_in = 8'hA4;
        wait_cyc(LAT_EDGE + 2);
        check("fall_ignored", 32'(irq_flags), 32'h00);

        // Falling edge on pin 3 coinciding with its clear: set wins.
        edge_en  = 8'h08;
        edge_pol = 8'h00;
        io_in    = 8'hAC;
        wait_cyc(LAT_EDGE + 2);
        check("rise_ignored", 32'(irq_flags), 32'h00);
        io_in = 8'hA4;
        wait_cyc(LAT_EDGE - 1);
        irq_clr = 8'h08;
        wait_cyc(1);
        irq_clr = 8'h00;
        check("set_wins", 32'(irq_flags), 32'h08);
        edge_pol = 8'h08;
        wait_cyc(2);
        check("pol_keeps", 32'(irq_flags), 32'h08);
        port_dir = 8'h08;
        wait_cyc(2);
        check("dir_keeps", 32'(irq_flags), 32'h08);
        irq_clr = 8'h08;
        wait_cyc(1);
        irq_clr  = 8'h00;
        port_dir = 8'h00;
        check("clr3", 32'(irq_flags), 32'h00);

        // Build flags 3C from mixed-polarity edges.
        edge_pol = 8'h18;
        edge_en  = 8'h3C;
        io_in    = 8'h98;
        wait_cyc(LAT_EDGE + 1);
        check("multi_flags", 32'(irq_flags), 32'h3C);
        check("multi_irq", 32'(irq), 32'h1);
        port_rd = 1'b1;
        wait_cyc(1);
        check("pre_rst_valid", 32'(read_valid), 32'h1);
        check("pre_rst_data", 32'(port_read_data), 32'h98);

        // Asynchronous reset mid-operation with a read in flight.
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", 32'(irq_flags), 32'h00);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_valid", 32'(read_valid), 32'h0);
        check("arst_data", 32'(port_read_data), 32'h00);
        wait_cyc(1);
        check("arst_hold_valid", 32'(read_valid), 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            wait_cyc(1);
            check("rewarm_flags", 32'(irq_flags), 32'h00);
        end
        check("rewarm_valid", 32'(read_valid), 32'h1);
        check("rewarm_data", 32'(port_read_data), 32'h98);
        port_rd = 1'b0;
        wait_cyc(1);
        check("rewarm_valid_end", 32'(read_valid), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Short glitch is filtered; a stable level is accepted.
        edge_en  = 8'h02;
        edge_pol = 8'h02;
        io_in    = 8'h9A;
        wait_cyc(3);
        io_in = 8'h98;
        wait_cyc(15);
        check("glitch_flags", 32'(irq_flags), 32'h00);
        port_rd = 1'b1;
        wait_cyc(1);
        port_rd = 1'b0;
        check("glitch_data", 32'(port_read_data), 32'h98);
        io_in = 8'h9A;
        wait_cyc(15);
        check("stable_flags", 32'(irq_flags), 32'h02);
        port_rd = 1'b1;
        wait_cyc(1);
        port_rd = 1'b0;
        check("stable_data", 32'(port_read_data), 32'h9A);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_input_capture.md
Name: gpio_input_capture

Overview:
- Input-side (read) half of the GPIO port: samples the external pins, synchronizes them to CLK, and returns a registered snapshot on a port-read strobe.
- Also detects per-pin edges into sticky interrupt flags.
- Sits beside the port direction and port data registers. Pins configured as outputs are masked from capture.

Parameters:
- WIDTH, 8, number of GPIO pins.
- SYNC_STAGES, 2, synchronizer flop depth per pin (legal range 2..4).
- DEBOUNCE_CYCLES, 4, stable-sample count for the debounce filter. Used only with GPIO_DEBOUNCE_EN.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IO_IN  input  WIDTH  raw asynchronous pin levels.
- PORT_DIR  input  WIDTH  per-pin direction from the port direction register: 1 = output (masked), 0 = input.
- PORT_RD  input  1  read strobe, sampled on the rising edge of CLK.
- PORT_READ_DATA  output  WIDTH  registered snapshot of the synchronized input levels.
- READ_VALID  output  1  high for the cycle after each sampled PORT_RD.
- EDGE_EN  input  WIDTH  per-pin edge-detect enable.
- EDGE_POL  input  WIDTH  per-pin polarity: 1 = rising, 0 = falling.
- IRQ_CLR  input  WIDTH  per-pin write-1-to-clear for IRQ_FLAGS.
- IRQ_FLAGS  output  WIDTH  sticky edge flags.
- IRQ  output  1  OR-reduction of IRQ_FLAGS.

Behaviour:
- Reset (RST_N low, asynchronous): all of the following clear to 0.
  - Synchronizer flops, previous-sample register, warm-up counter.
  - PORT_READ_DATA, READ_VALID, IRQ_FLAGS, IRQ.
  - FSM goes to WARMUP.
- Synchronizer: IO_IN passes through SYNC_STAGES flops per bit. A pin change appears at the sync output SYNC_STAGES rising edges later. The result is named sync_q.
- Previous-sample register: prev_q <= sync_q every cycle.
- FSM:
  - WARMUP: counter increments each cycle. When it reaches SYNC_STAGES+1, go to RUN. Edge detection is suppressed in WARMUP, so a pin already high out of reset never raises a spurious rising-edge flag. Reads are still serviced in WARMUP.
  - RUN: normal operation. Returns to WARMUP only via reset.
  - Reset asserted mid-operation: immediate return to WARMUP with all state cleared. A read in flight is lost; READ_VALID is 0.
- Read path:
  - PORT_RD high at edge N gives, at edge N: PORT_READ_DATA <= sync_q & ~PORT_DIR, and READ_VALID <= 1.
  - Latency: 1 cycle from the strobe.
  - PORT_RD held high for k cycles gives k consecutive fresh snapshots, with READ_VALID high for k cycles.
  - PORT_RD low: READ_VALID <= 0. PORT_READ_DATA holds its last value.
  - Output-configured pins always read 0.
- Edge detect, per bit i, in RUN only:
  - rise = sync_q & ~prev_q
  - fall = ~sync_q & prev_q
  - det[i] = EDGE_EN[i] & ~PORT_DIR[i] & (EDGE_POL[i] ? rise[i] : fall[i])
- Flags:
  - IRQ_FLAGS[i] <= det[i] | (IRQ_FLAGS[i] & ~IRQ_CLR[i]).
  - Set and clear in the same cycle: set wins and the flag stays 1.
  - A repeated edge on an already-set flag leaves it at 1. There is no counting.
- IRQ: combinational OR of registered IRQ_FLAGS, so it is glitch-free.
- Runtime changes:
  - Changing EDGE_POL or EDGE_EN never clears existing flags.
  - Switching a pin to output does not clear its flag. It only blocks new detections.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - A per-pin counter follows the synchronizer.
  - The filtered level updates only after sync_q differs from the current filtered level for DEBOUNCE_CYCLES consecutive cycles. Any bounce resets that pin's counter.
  - Read data and edge detection both use the filtered level.
  - Added latency is DEBOUNCE_CYCLES cycles.
  - WARMUP length becomes SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - Filtered levels and counters reset to 0.
- Undefined: sync_q is used directly, with no added latency or area.

Test Plan:
- Reset release with IO_IN=8'hFF, PORT_DIR=0, EDGE_EN=8'hFF, EDGE_POL=8'hFF -> IRQ_FLAGS stays 8'h00 and IRQ=0 through WARMUP and after.
- IO_IN=8'hA5, PORT_DIR=8'h0F, wait 3 cycles, pulse PORT_RD for 1 cycle -> next cycle PORT_READ_DATA=8'hA0 and READ_VALID=1 for exactly one cycle.
- EDGE_EN=8'h01, EDGE_POL=8'h01, IO_IN[0] goes 0->1 in RUN -> IRQ_FLAGS=8'h01 and IRQ=1 SYNC_STAGES+1 edges later. Driving IRQ_CLR=8'h01 for 1 cycle -> IRQ_FLAGS=8'h00.
- EDGE_POL[3]=0 and IO_IN[3] falls in the same cycle that IRQ_CLR[3]=1 -> IRQ_FLAGS[3] remains 1 (set wins).
- RST_N pulsed low mid-operation with flags at 8'h3C and PORT_RD high -> all outputs 0 asynchronously. After release, WARMUP repeats and no edges are flagged.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 3-cycle glitch on IO_IN[1] -> no flag and read data unchanged. A stable level for 4+ cycles -> flag set and read value updates.
